// File: rtl/seg7_pkg.sv
// Shared definitions for the multi-digit 7-segment driver:
// active-low glyph codes (bit0=a .. bit6=g), blank/dash codes and FSM states.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h18;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_UPDATE  = 2'd2
   } state_t;

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational nibble -> active-low 7-segment glyph lookup (0..F).
module seg7_glyph_rom
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Hex glyph table, active-low encoding
   always_comb begin
      case (nibble)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         default: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg7_multi_digit_driver.sv
// Registered driver for DIGITS 7-segment displays. A value accepted on LOAD
// is shown in hex, or in decimal after a DATA_W-cycle double-dabble pass.
// Out-of-range values show dashes and raise OVF until the next update.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_multi_digit_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int DATA_W         = 14,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  CLOCK_50,
   input  logic                  RST_N,
   input  logic [DATA_W-1:0]     DATA,
   input  logic                  MODE_DEC,
   input  logic                  LOAD,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  OVF,
   output logic [7*DIGITS-1:0]   HEX
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + DATA_W;
   localparam int EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
   // XOR mask turning the internal active-low codes into the board polarity
   localparam logic [6:0] POL_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;

   state_t                state_reg;
   logic [SR_W-1:0]       sr_reg;
   logic [SR_W-1:0]       sr_adj;
   logic [SR_W-1:0]       sr_next;
   logic                  carry_out;
   logic [5:0]            cnt_reg;
   logic                  ovf_int_reg;
   logic                  ovf_reg;
   logic                  done_reg;
   logic [7*DIGITS-1:0]   hex_reg;
   logic [7*DIGITS-1:0]   hex_next;
   logic [EXT_W-1:0]      data_ext;
   logic                  hex_ovf;
   logic [BCD_W-1:0]      bcd;
   logic [DIGITS-1:0]     blank;
   logic [6:0]            glyph [DIGITS];

   // Zero-extend the input so hex nibbles and the hex overflow test are width-safe
   always_comb begin
      data_ext = EXT_W'(DATA);
      hex_ovf  = |(data_ext >> BCD_W);
   end

   // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left
   always_comb begin
      sr_adj = sr_reg;
      for (int k = 0; k < DIGITS; k++) begin
         if (sr_adj[DATA_W+4*k +: 4] >= 4'd5)
            sr_adj[DATA_W+4*k +: 4] = sr_adj[DATA_W+4*k +: 4] + 4'd3;
      end
      carry_out = sr_adj[SR_W-1];
      sr_next   = {sr_adj[SR_W-2:0], 1'b0};
   end

   // Digit nibbles always live in the top of the shift register (both modes)
   assign bcd = sr_reg[SR_W-1 -: BCD_W];

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_rom
         seg7_glyph_rom u_rom (
            .nibble (bcd[4*gi +: 4]),
            .seg    (glyph[gi])
         );
      end
   endgenerate

   // Leading-zero blanking mask; digit 0 is never blanked
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic lead;
   always_comb begin
      blank = '0;
      lead  = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (lead && (bcd[4*k +: 4] == 4'd0))
            blank[k] = 1'b1;
         else
            lead = 1'b0;
      end
   end
`else
   always_comb begin
      blank = '0;
   end
`endif

   // Final per-digit code: dash on overflow, else blank or glyph, then polarity
   always_comb begin
      hex_next = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (ovf_int_reg)
            hex_next[7*k +: 7] = SEG_DASH ^ POL_MASK;
         else if (blank[k])
            hex_next[7*k +: 7] = SEG_BLANK ^ POL_MASK;
         else
            hex_next[7*k +: 7] = glyph[k] ^ POL_MASK;
      end
   end

   // Control FSM: latch, convert (decimal only), then register the display
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         state_reg   <= ST_IDLE;
         sr_reg      <= '0;
         cnt_reg     <= '0;
         ovf_int_reg <= 1'b0;
         ovf_reg     <= 1'b0;
         done_reg    <= 1'b0;
         hex_reg     <= {DIGITS{SEG_BLANK ^ POL_MASK}};
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (LOAD) begin
                  if (MODE_DEC) begin
                     sr_reg      <= {{BCD_W{1'b0}}, DATA};
                     cnt_reg     <= 6'(DATA_W - 1);
                     ovf_int_reg <= 1'b0;
                     state_reg   <= ST_CONVERT;
                  end else begin
                     sr_reg      <= {data_ext[BCD_W-1:0], {DATA_W{1'b0}}};
                     ovf_int_reg <= hex_ovf;
                     state_reg   <= ST_UPDATE;
                  end
               end
            end
            ST_CONVERT: begin
               sr_reg <= sr_next;
               if (carry_out)
                  ovf_int_reg <= 1'b1;
               if (cnt_reg == 6'd0)
                  state_reg <= ST_UPDATE;
               else
                  cnt_reg <= cnt_reg - 6'd1;
            end
            ST_UPDATE: begin
               hex_reg   <= hex_next;
               ovf_reg   <= ovf_int_reg;
               done_reg  <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign BUSY = (state_reg != ST_IDLE);
   assign DONE = done_reg;
   assign OVF  = ovf_reg;
   assign HEX  = hex_reg;

endmodule

// File: tb/tb_seg7_multi_digit_driver.sv
// Self-checking bench for seg7_multi_digit_driver (DIGITS=4, DATA_W=14).
// Expected displays come from a behavioural model pushed to a scoreboard
// at each accepted load and compared whenever DONE pulses.
module tb_seg7_multi_digit_driver;

   localparam int DIGITS         = 4;
   localparam int DATA_W         = 14;
   localparam int SEG_ACTIVE_LOW = 1;
   localparam int HW             = 7 * DIGITS;

   logic              CLOCK_50 = 1'b0;
   logic              RST_N    = 1'b0;
   logic [DATA_W-1:0] DATA     = '0;
   logic              MODE_DEC = 1'b0;
   logic              LOAD     = 1'b0;
   logic              BUSY;
   logic              DONE;
   logic              OVF;
   logic [HW-1:0]     HEX;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [HW-1:0] hex;
      logic          ovf;
      int            value;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   seg7_multi_digit_driver #(
      .DIGITS         (DIGITS),
      .DATA_W         (DATA_W),
      .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RST_N    (RST_N),
      .DATA     (DATA),
      .MODE_DEC (MODE_DEC),
      .LOAD     (LOAD),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .OVF      (OVF),
      .HEX      (HEX)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic logic [6:0] glyph(input int n);
      case (n)
         0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
         4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
         8: return 7'h00;   9: return 7'h18;  10: return 7'h08;  11: return 7'h03;
        12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [6:0] pol(input logic [6:0] c);
      return (SEG_ACTIVE_LOW != 0) ? c : ~c;
   endfunction

   function automatic exp_t model(input int value, input bit dec);
      exp_t       e;
      int         nib [DIGITS];
      bit         lead;
      logic [6:0] code;
      e.value = value;
      e.hex   = '0;
      if (dec) begin
         e.ovf = (value >= 10 ** DIGITS);
         for (int k = 0; k < DIGITS; k++) nib[k] = (value / (10 ** k)) % 10;
      end else begin
         e.ovf = ((value >> (4 * DIGITS)) != 0);
         for (int k = 0; k < DIGITS; k++) nib[k] = (value >> (4 * k)) & 15;
      end
      lead = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         code = glyph(nib[k]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         if (lead && k > 0 && nib[k] == 0) code = 7'h7F;
         else lead = 1'b0;
`else
         lead = 1'b0;
`endif
         if (e.ovf) code = 7'h3F;
         e.hex[7*k +: 7] = pol(code);
      end
      return e;
   endfunction

   // Scoreboard consumer: every DONE pulse must match the oldest expectation
   always @(negedge CLOCK_50) begin
      if (RST_N && DONE) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done HEX=%h OVF=%b (no load pending)", HEX, OVF);
         end else begin
            mon_e = sb.pop_front();
            if (HEX !== mon_e.hex) begin
               errors++;
               $display("FAIL done_hex value=%0d got %h expected %h", mon_e.value, HEX, mon_e.hex);
            end
            checks++;
            if (OVF !== mon_e.ovf) begin
               errors++;
               $display("FAIL done_ovf value=%0d got %b expected %b", mon_e.value, OVF, mon_e.ovf);
            end
            $display("txn value=%0d HEX=%h OVF=%b", mon_e.value, HEX, OVF);
         end
      end
   end

   // Drive one load and report DONE latency (-1 on timeout) and BUSY cycles
   task automatic do_load(input int value, input bit dec, output int lat, output int busy_n);
      int  cyc;
      bit  seen;
      @(negedge CLOCK_50);
      DATA     = DATA_W'(value);
      MODE_DEC = dec;
      LOAD     = 1'b1;
      sb.push_back(model(value, dec));
      cyc    = 0;
      busy_n = 0;
      seen   = 1'b0;
      while (cyc < 200 && !seen) begin
         @(negedge CLOCK_50);
         cyc++;
         if (cyc == 1) LOAD = 1'b0;
         if (BUSY) busy_n++;
         if (DONE) seen = 1'b1;
      end
      lat = seen ? cyc : -1;
   endtask

   task automatic test_reset();
      @(negedge CLOCK_50);
      checks++;
      if (HEX !== {DIGITS{7'h7F}}) begin errors++; $display("FAIL reset_hex got %h expected %h", HEX, {DIGITS{7'h7F}}); end
      checks++;
      if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", BUSY); end
      checks++;
      if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", DONE); end
      checks++;
      if (OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b expected 0", OVF); end
      @(negedge CLOCK_50);
      RST_N = 1'b1;
      @(negedge CLOCK_50);
   endtask

   task automatic test_hex();
      int lat, bn;
      do_load(16'h3A7F, 1'b0, lat, bn);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL hex_latency got %0d expected 2", lat); end
      checks++;
      if (bn !== 1) begin errors++; $display("FAIL hex_busy_cycles got %0d expected 1", bn); end
      checks++;
      if (HEX !== {7'h30, 7'h08, 7'h78, 7'h0E}) begin
         errors++; $display("FAIL hex_3A7F got %h expected %h", HEX, {7'h30, 7'h08, 7'h78, 7'h0E});
      end
   endtask

   task automatic test_decimal();
      int lat, bn;
      do_load(9876, 1'b1, lat, bn);
      checks++;
      if (lat !== DATA_W + 2) begin errors++; $display("FAIL dec_latency got %0d expected %0d", lat, DATA_W + 2); end
      checks++;
      if (bn !== DATA_W + 1) begin errors++; $display("FAIL dec_busy_cycles got %0d expected %0d", bn, DATA_W + 1); end
      checks++;
      if (HEX !== {7'h18, 7'h00, 7'h78, 7'h02}) begin
         errors++; $display("FAIL dec_9876 got %h expected %h", HEX, {7'h18, 7'h00, 7'h78, 7'h02});
      end
   endtask

   task automatic test_overflow();
      int lat, bn;
      do_load(10000, 1'b1, lat, bn);
      checks++;
      if (OVF !== 1'b1 || HEX !== {DIGITS{7'h3F}}) begin
         errors++; $display("FAIL ovf_10000 got OVF=%b HEX=%h expected OVF=1 HEX=%h", OVF, HEX, {DIGITS{7'h3F}});
      end
      do_load(9999, 1'b1, lat, bn);
      checks++;
      if (OVF !== 1'b0 || HEX !== {DIGITS{7'h18}}) begin
         errors++; $display("FAIL ovf_9999 got OVF=%b HEX=%h expected OVF=0 HEX=%h", OVF, HEX, {DIGITS{7'h18}});
      end
   endtask

   task automatic test_load_busy();
      exp_t e;
      int   dones;
      @(negedge CLOCK_50);
      DATA     = DATA_W'(1234);
      MODE_DEC = 1'b1;
      LOAD     = 1'b1;
      e        = model(1234, 1'b1);
      sb.push_back(e);
      dones = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge CLOCK_50);
         if (cyc == 1) LOAD = 1'b0;
         if (cyc == 5) begin DATA = DATA_W'(1); LOAD = 1'b1; end
         if (cyc == 6) LOAD = 1'b0;
         if (DONE) dones++;
      end
      checks++;
      if (dones !== 1) begin errors++; $display("FAIL busy_load_done_count got %0d expected 1", dones); end
      checks++;
      if (HEX !== e.hex) begin errors++; $display("FAIL busy_load_hex got %h expected %h", HEX, e.hex); end
   endtask

   task automatic test_leading_zero();
      int lat, bn;
      logic [HW-1:0] exp42, exp0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      exp42 = {7'h7F, 7'h7F, 7'h19, 7'h24};
      exp0  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
      exp42 = {7'h40, 7'h40, 7'h19, 7'h24};
      exp0  = {7'h40, 7'h40, 7'h40, 7'h40};
`endif
      do_load(42, 1'b1, lat, bn);
      checks++;
      if (HEX !== exp42) begin errors++; $display("FAIL lz_42 got %h expected %h", HEX, exp42); end
      do_load(0, 1'b1, lat, bn);
      checks++;
      if (HEX !== exp0) begin errors++; $display("FAIL lz_0 got %h expected %h", HEX, exp0); end
      checks++;
      if (lat !== DATA_W + 2) begin errors++; $display("FAIL lz_latency got %0d expected %0d", lat, DATA_W + 2); end
   endtask

   task automatic test_back_to_back();
      int dones;
      @(negedge CLOCK_50);
      DATA     = DATA_W'(16'h0005);
      MODE_DEC = 1'b0;
      LOAD     = 1'b1;
      sb.push_back(model(16'h0005, 1'b0));
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      checks++;
      if (DONE !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b expected 1", DONE); end
      DATA = DATA_W'(16'h1ABC);
      sb.push_back(model(16'h1ABC, 1'b0));
      @(negedge CLOCK_50);
      LOAD = 1'b0;
      checks++;
      if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_retrigger_busy got %b expected 1", BUSY); end
      @(negedge CLOCK_50);
      checks++;
      if (DONE !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b expected 1", DONE); end
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLOCK_50);
         if (DONE) dones++;
      end
      checks++;
      if (dones !== 0) begin errors++; $display("FAIL b2b_extra_done got %0d expected 0", dones); end
   endtask

   task automatic test_random();
      int lat, bn, v;
      bit d;
      for (int i = 0; i < 10; i++) begin
         v = $urandom_range(0, (1 << DATA_W) - 1);
         d = 1'($urandom_range(0, 1));
         do_load(v, d, lat, bn);
         checks++;
         if (lat !== (d ? DATA_W + 2 : 2)) begin
            errors++; $display("FAIL rand_latency value=%0d dec=%b got %0d expected %0d", v, d, lat, d ? DATA_W + 2 : 2);
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat, bn;
      // leave OVF=1 and dashes on the display before resetting mid-conversion
      do_load(12345, 1'b1, lat, bn);
      @(negedge CLOCK_50);
      DATA     = DATA_W'(777);
      MODE_DEC = 1'b1;
      LOAD     = 1'b1;
      sb.push_back(model(777, 1'b1));
      for (int cyc = 1; cyc <= 5; cyc++) begin
         @(negedge CLOCK_50);
         if (cyc == 1) LOAD = 1'b0;
      end
      #2;
      RST_N = 1'b0;
      #1;
      sb.delete();
      checks++;
      if (HEX !== {DIGITS{7'h7F}}) begin errors++; $display("FAIL midreset_hex got %h expected %h", HEX, {DIGITS{7'h7F}}); end
      checks++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || OVF !== 1'b0) begin
         errors++; $display("FAIL midreset_flags got BUSY=%b DONE=%b OVF=%b expected 0 0 0", BUSY, DONE, OVF);
      end
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      RST_N = 1'b1;
      do_load(16'h0123, 1'b0, lat, bn);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL midreset_recover_latency got %0d expected 2", lat); end
   endtask

   initial begin
      test_reset();
      test_hex();
      test_decimal();
      test_overflow();
      test_load_busy();
      test_leading_zero();
      test_back_to_back();
      test_random();
      test_reset_mid();
      repeat (3) @(negedge CLOCK_50);
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d expected 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
